// File: rtl/tff_modn_counter_pkg.sv
// Shared constants for the modulo-N T-flip-flop counter: default geometry,
// direction encodings and the per-edge operation selected by the control inputs.
package tff_modn_counter_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Operation applied on the next edge, after resolving load > en > hold.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DN   = 2'd3
  } count_op_e;

endpackage

// File: rtl/tff_modn_counter_cell.sv
// Single T-type storage cell: toggles on a rising edge when t is high,
// clears asynchronously on reset.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_modn_counter.sv
// Modulo-N up/down counter whose state lives entirely in T cells; this module
// only derives each cell's toggle input from the desired next count.
module tff_modn_counter
  import tff_modn_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("tff_modn_counter: MODULUS must lie in 2..2**WIDTH");
  end

  // One extra bit keeps MODULUS-1 and q+1 exact when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MOD_M1  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

  count_op_e        op;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lv_ext;
  logic [WIDTH:0]   nxt_ext;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t;
  logic             at_top;
  logic             at_bot;
  logic             in_range;
  logic             wrap_d;
  logic             err_d;
  logic             unused_msb;

  assign q_ext    = {1'b0, q};
  assign lv_ext   = {1'b0, load_val};
  assign in_range = (lv_ext < MOD_EXT);
  // Unreachable states above MODULUS-1 are treated as the top so count-up recovers to 0.
  assign at_top   = (q_ext >= MOD_M1);
  assign at_bot   = (q_ext == '0);

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = (up == DIR_UP) ? OP_UP : OP_DN;
    end
  end

  always_comb begin
    nxt_ext = q_ext;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (op)
      OP_LOAD: begin
        nxt_ext = in_range ? lv_ext : MOD_M1;
        err_d   = ~in_range;
      end
      OP_UP: begin
        nxt_ext = at_top ? '0 : (q_ext + ONE);
        wrap_d  = at_top;
      end
      OP_DN: begin
        nxt_ext = at_bot ? MOD_M1 : (q_ext - ONE);
        wrap_d  = at_bot;
      end
      default: begin
        nxt_ext = q_ext;
      end
    endcase
  end

  assign q_next     = nxt_ext[WIDTH-1:0];
  assign unused_msb = nxt_ext[WIDTH];
  assign t          = q ^ q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  assign tc = en & ~load & ((up == DIR_UP) ? (q_ext == MOD_M1) : at_bot);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_d;
      load_err <= err_d;
    end
  end

endmodule
